// File: rtl/ifetch_buffer.sv
// Instruction-fetch front end: issues word reads, tracks outstanding and dropped responses,
// and buffers returned instructions with their PCs in an in-order FIFO toward decode.
module ifetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] fetch_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;

  logic [31:0]   r_fetch_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];

  logic [SW-1:0] w_credit_sum;
  logic          w_fire;
  logic          w_rsp_drop;
  logic          w_rsp_accept;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_rsp_pc;
  logic          w_unused;

  assign w_unused = ^redirect_pc[1:0];

  // Every buffered entry, outstanding request and pending drop consumes one credit.
  assign w_credit_sum = SW'(r_count) + SW'(r_outstanding) + SW'(r_drop);
  assign mem_req      = !rst && !redirect_valid && (w_credit_sum < SW'(DEPTH));
  assign mem_addr     = r_fetch_pc;
  assign fetch_pc     = r_fetch_pc;

  assign w_fire       = mem_req && mem_gnt;
  assign w_rsp_drop   = mem_rvalid && (r_drop != '0);
  assign w_rsp_accept = mem_rvalid && (r_drop == '0) && (r_outstanding != '0);
  assign w_push       = w_rsp_accept && !redirect_valid;
  assign w_pop        = out_valid && out_ready;

  // Responses are in order, so the oldest outstanding request sits this far behind fetch_pc.
  assign w_rsp_pc     = r_fetch_pc - (32'(r_outstanding) << 2);

  assign out_valid    = (r_count != '0);
  assign out_pc       = out_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;
  assign out_instr    = out_valid ? r_instr_mem[r_rd_ptr] : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= {redirect_pc[31:2], 2'b00};
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      // Everything still in flight becomes a drop; a response landing now retires one of them.
      r_drop        <= r_drop + r_outstanding - CW'(w_rsp_drop || w_rsp_accept);
    end else begin
      if (w_fire)
        r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_rsp_accept);
      if (w_rsp_drop)
        r_drop <= r_drop - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= w_rsp_pc;
      r_instr_mem[r_wr_ptr] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: a latency-configurable memory model feeds a
// scoreboard of expected {pc, instr} pairs that is compared on every decode handshake.
module tb_ifetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] fetch_pc;

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          ovalid_cnt = 0;
  bit          gnt_en = 1'b0;
  pend_t       pend[$];
  logic [63:0] exp_q[$];
  logic [31:0] grant_log[$];
  logic [31:0] pop_log[$];
  logic [63:0] exp_e;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory model drives at negedge+1; scoreboard samples at negedge+3; tasks check at negedge+4.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    mem_gnt = gnt_en;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = word_of(pend[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    #2;
    if (mem_rvalid) void'(pend.pop_front());
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) ovalid_cnt++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_pop got pc=%h instr=%h required no entry", out_pc, out_instr);
        end else begin
          exp_e = exp_q.pop_front();
          if ({out_pc, out_instr} !== exp_e) begin
            errors++;
            $display("FAIL sb_pop got pc=%h instr=%h required pc=%h instr=%h",
                     out_pc, out_instr, exp_e[63:32], exp_e[31:0]);
          end
        end
        pop_log.push_back(out_pc);
      end
      if (redirect_valid) exp_q.delete();
      if (mem_req && mem_gnt) begin
        grant_log.push_back(mem_addr);
        pend.push_back('{mem_addr, cyc + lat});
        exp_q.push_back({mem_addr, word_of(mem_addr)});
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    gnt_en = 1'b0;
    lat = 1;
    pend.delete();
    grant_log.delete();
    pop_log.delete();
    step();
    step();
    rst = 1'b0;
    ovalid_cnt = 0;
  endtask

  task automatic drain();
    int n = 0;
    gnt_en = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || pend.size() != 0) && n < 50) begin
      step();
      n++;
    end
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d entries left required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    step();
    rst = 1'b1;
    gnt_en = 1'b1;
    #4;
    checks += 6;
    if (mem_req !== 1'b0)       begin errors++; $display("FAIL rst_mem_req got %b required 0", mem_req); end
    if (out_valid !== 1'b0)     begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    if (mem_addr !== RESET_PC)  begin errors++; $display("FAIL rst_mem_addr got %h required %h", mem_addr, RESET_PC); end
    if (fetch_pc !== RESET_PC)  begin errors++; $display("FAIL rst_fetch_pc got %h required %h", fetch_pc, RESET_PC); end
    if (out_pc !== 32'h0)       begin errors++; $display("FAIL rst_out_pc got %h required 0", out_pc); end
    if (out_instr !== 32'h0)    begin errors++; $display("FAIL rst_out_instr got %h required 0", out_instr); end
    gnt_en = 1'b0;
    step();
    rst = 1'b0;
    #4;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_release_req got %b required 1", mem_req); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    gnt_en = 1'b1;
    lat = 1;
    repeat (12) step();
    gnt_en = 1'b0;
    #4;
    checks++;
    if (grant_log.size() != 12) begin
      errors++;
      $display("FAIL stream_grants got %0d required 12", grant_log.size());
    end
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
      checks++;
      if (grant_log[i] !== 32'(i * 4)) begin
        errors++;
        $display("FAIL stream_addr[%0d] got %h required %h", i, grant_log[i], 32'(i * 4));
      end
    end
    drain();
    checks++;
    if (pop_log.size() != 12) begin
      errors++;
      $display("FAIL stream_pops got %0d required 12", pop_log.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    gnt_en = 1'b1;
    repeat (10) step();
    #4;
    checks += 4;
    if (grant_log.size() != 4) begin errors++; $display("FAIL bp_grants got %0d required 4", grant_log.size()); end
    if (mem_req !== 1'b0)      begin errors++; $display("FAIL bp_mem_req got %b required 0", mem_req); end
    if (out_valid !== 1'b1)    begin errors++; $display("FAIL bp_out_valid got %b required 1", out_valid); end
    if (out_pc !== 32'h0)      begin errors++; $display("FAIL bp_head_pc got %h required 0", out_pc); end
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      checks++;
      if (grant_log[i] !== 32'(i * 4)) begin
        errors++;
        $display("FAIL bp_addr[%0d] got %h required %h", i, grant_log[i], 32'(i * 4));
      end
    end
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (4) step();
    #4;
    checks += 2;
    if (grant_log.size() != 5) begin
      errors++;
      $display("FAIL bp_one_per_pop got %0d required 5", grant_log.size());
    end else if (grant_log[4] !== 32'h10) begin
      errors++;
      $display("FAIL bp_next_addr got %h required 00000010", grant_log[4]);
    end
    if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_full_again got %b required 0", mem_req); end
    // Redirect with a concurrent pop: the handshake completes but the FIFO is flushed.
    step();
    gnt_en = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    #4;
    checks += 2;
    if (out_valid !== 1'b0)       begin errors++; $display("FAIL flush_out_valid got %b required 0", out_valid); end
    if (mem_addr !== 32'h40)      begin errors++; $display("FAIL flush_mem_addr got %h required 00000040", mem_addr); end
    step();
    gnt_en = 1'b1;
    step();
    step();
    drain();
    checks++;
    if (pop_log.size() == 0 || pop_log[pop_log.size() - 1] !== 32'h44) begin
      errors++;
      $display("FAIL flush_last_pop got %h required 00000044",
               (pop_log.size() == 0) ? 32'hX : pop_log[pop_log.size() - 1]);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b1;
    lat = 3;
    gnt_en = 1'b1;
    step();
    step();
    gnt_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    gnt_en = 1'b1;
    #4;
    checks += 2;
    if (mem_addr !== 32'h100) begin errors++; $display("FAIL redir_mem_addr got %h required 00000100", mem_addr); end
    if (fetch_pc !== 32'h100) begin errors++; $display("FAIL redir_fetch_pc got %h required 00000100", fetch_pc); end
    step();
    gnt_en = 1'b0;
    drain();
    checks += 3;
    if (grant_log.size() != 3) begin
      errors++;
      $display("FAIL redir_grants got %0d required 3", grant_log.size());
    end
    if (pop_log.size() != 1 || pop_log[0] !== 32'h100) begin
      errors++;
      $display("FAIL redir_first_pop got count %0d pc %h required count 1 pc 00000100",
               pop_log.size(), (pop_log.size() == 0) ? 32'hX : pop_log[0]);
    end
    if (ovalid_cnt != 1) begin
      errors++;
      $display("FAIL redir_empty_until got %0d valid cycles required 1", ovalid_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    lat = 4;
    gnt_en = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    gnt_en = 1'b0;
    step();
    rst = 1'b0;
    ovalid_cnt = 0;
    repeat (5) step();
    #4;
    checks += 4;
    if (ovalid_cnt != 0)       begin errors++; $display("FAIL mid_rst_stray got %0d valid cycles required 0", ovalid_cnt); end
    if (out_valid !== 1'b0)    begin errors++; $display("FAIL mid_rst_out_valid got %b required 0", out_valid); end
    if (mem_addr !== RESET_PC) begin errors++; $display("FAIL mid_rst_mem_addr got %h required %h", mem_addr, RESET_PC); end
    if (mem_req !== 1'b1)      begin errors++; $display("FAIL mid_rst_mem_req got %b required 1", mem_req); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    gnt_en = 1'b1;
    step();
    step();
    drain();
    checks += 2;
    if (grant_log.size() != 2 || grant_log[0] !== 32'hFFFF_FFFC || grant_log[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr got count %0d required FFFFFFFC then 00000000", grant_log.size());
    end
    if (pop_log.size() != 2 || pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_out_pc got count %0d required FFFFFFFC then 00000000", pop_log.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b1;
    gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      #4;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== RESET_PC || fetch_pc !== RESET_PC) begin
        errors++;
        $display("FAIL stall_hold[%0d] got req=%b addr=%h pc=%h required req=1 addr=%h",
                 i, mem_req, mem_addr, fetch_pc, RESET_PC);
      end
    end
    step();
    gnt_en = 1'b1;
    step();
    gnt_en = 1'b0;
    #4;
    checks += 2;
    if (fetch_pc !== RESET_PC + 32'd4) begin
      errors++;
      $display("FAIL stall_advance got %h required %h", fetch_pc, RESET_PC + 32'd4);
    end
    if (grant_log.size() != 1) begin
      errors++;
      $display("FAIL stall_grants got %0d required 1", grant_log.size());
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_reset_mid();
    test_wrap();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end

endmodule

// File: doc/ifetch_buffer.md
Name: ifetch_buffer

Overview:
- Instruction-fetch front end and consumer of the program-counter address stream.
- Owns the fetch PC and issues word reads to instruction memory over a req/gnt/rvalid bus.
- Buffers returned instructions, each with its PC, in an in-order FIFO toward decode (valid/ready).
- On a branch or jump redirect, flushes the FIFO and discards in-flight responses.

Parameters:
- DEPTH, 4: FIFO entries; also the credit limit (buffered entries + outstanding requests <= DEPTH); power of two, >= 2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
- mem_req  output  1  read request.
- mem_addr  output  32  word address of the request; bits [1:0] always 0.
- mem_gnt  input  1  request accepted this cycle; only meaningful when mem_req=1.
- mem_rvalid  input  1  read data valid; responses arrive in order, at most one per cycle, at least 1 cycle after gnt.
- mem_rdata  input  32  instruction word.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  decode accepts head.
- out_pc  output  32  PC of the head instruction.
- out_instr  output  32  head instruction.
- fetch_pc  output  32  next address to be requested (debug/observe).

Behaviour:
- State registers: fetch_pc, FIFO storage (pc, instr) x DEPTH, rd/wr pointers, count (0..DEPTH), outstanding (0..DEPTH), drop (0..DEPTH).
- Reset (async, any time, including mid-transaction):
  - fetch_pc = RESET_PC; count = outstanding = drop = 0.
  - mem_req = 0, out_valid = 0.
  - mem_addr = fetch_pc; out_pc/out_instr read 0.
  - Any mem_rvalid after reset with outstanding = 0 is ignored.
- mem_req = !rst && !redirect_valid && (count + outstanding + drop < DEPTH). Combinational; mem_addr = fetch_pc.
- Request fire = mem_req && mem_gnt:
  - fetch_pc <= fetch_pc + 4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
  - outstanding++.
  - The PC of each outstanding request is its mem_addr, held in a small in-order tag queue, or reconstructed as fetch_pc - 4*(outstanding) at response time.
- Response (mem_rvalid):
  - If drop > 0: drop--, data discarded.
  - Else: push {pc, mem_rdata} into the FIFO; outstanding--.
  - The credit rule guarantees the FIFO is never full on an accepted response; an rvalid with outstanding = drop = 0 is a protocol error and is ignored.
- Pop: out_valid = (count != 0). On out_valid && out_ready the head advances.
- Simultaneous push and pop:
  - count unchanged, pointers both advance.
  - With count = 0, a push appears at out_valid on the next cycle. No bypass: response-to-out_valid latency is 1 cycle.
- Redirect (redirect_valid = 1 in cycle N):
  - mem_req = 0 in cycle N.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO flushed: count <= 0, pointers reset, out_valid = 0 from N+1.
  - drop <= drop + outstanding (minus 1 if a dropped or outstanding response also arrives in N); outstanding <= 0.
  - A pop in N is still honoured: the consumer sees the handshake, but the entry is flushed anyway.
  - A response arriving in cycle N is discarded.
  - First new request: cycle N+1, subject to credit.
- Redirect while drop > 0: the additional outstanding requests are added to drop; drops saturate at DEPTH by construction.
- Back-to-back redirects: the last one wins; each resets the fetch PC.
- Stalled gnt: mem_req/mem_addr held stable until gnt or redirect. Only a redirect may withdraw a request.

Test Plan:
- Reset, memory gnt=1 always, rvalid 1 cycle after gnt, out_ready=1:
  - mem_addr sequence 0,4,8,... one per cycle after credit ramp.
  - out_pc 0,4,8 with out_instr matching memory words.
- out_ready=0, DEPTH=4:
  - Exactly 4 requests issued (0,4,8,C), mem_req then low, count=4.
  - Raise out_ready: one new request per pop, next address 0x10.
- 2 requests outstanding (rdata latency 3), redirect_pc=0x103:
  - Next mem_addr = 0x100.
  - Two stale responses dropped.
  - First out_pc = 0x100 with its word, FIFO empty until then.
- Assert rst mid-burst with 3 outstanding; release; stray rvalid arrives:
  - Stray rvalid ignored, out_valid stays 0.
  - mem_addr = RESET_PC.
- Wrap test: redirect_pc = 0xFFFF_FFFC → requests FFFF_FFFC then 0x0000_0000; out_pc matches.
- mem_gnt held low 5 cycles: mem_req high and mem_addr stable all 5 cycles; fetch_pc advances only on the gnt cycle.
